// File: rtl/mtimer_pkg.sv
// Shared types and constants for the memory-mapped machine timer.
package mtimer_pkg;

  typedef enum logic [1:0] {
    MEM_OP_B = 2'b00,
    MEM_OP_H = 2'b01,
    MEM_OP_W = 2'b10
  } mem_op_e;

  localparam logic [31:0] MTIMER_BASE = 32'h1000_0000;

  // Word index within the window (adr[4:2])
  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_PRESCALE = 3'd5;
  localparam logic [2:0] OFF_SNAP_HI  = 3'd6;

  localparam int CTRL_EN_BIT = 0;

  // Misaligned halves/words are dropped rather than split across lanes.
  function automatic logic lane_ok(input logic [1:0] op, input logic [1:0] a);
    case (op)
      MEM_OP_B: lane_ok = 1'b1;
      MEM_OP_H: lane_ok = !a[0];
      MEM_OP_W: lane_ok = (a == 2'b00);
      default:  lane_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mtimer_if.sv
// CPU data-bus slice seen by the timer: ex-stage request, registered read return.
interface mtimer_if;
  logic [31:0] adr;
  logic [1:0]  op;
  logic        we;
  logic [31:0] wdin;
  logic [31:0] rdo;
  logic        hit;

  modport master (output adr, op, we, wdin, input  rdo, hit);
  modport slave  (input  adr, op, we, wdin, output rdo, hit);
endinterface

// File: rtl/mtimer_prescaler.sv
// Programmable divider producing the mtime increment strobe.
module mtimer_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] prescale,
  input  logic        clr,
  output logic        tick
);
  logic [31:0] psc_cnt;

  assign tick = en && (psc_cnt == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   psc_cnt <= '0;
    else if (!en || clr || tick)  psc_cnt <= '0;
    else                          psc_cnt <= psc_cnt + 32'd1;
  end
endmodule

// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp in a 32-byte window, level irq to clint.
module mtimer
  import mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = MTIMER_BASE,
  parameter int          CNT_WIDTH = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  mtimer_if.slave   bus,
  output logic      timer_irq
);
  logic [CNT_WIDTH-1:0] mtime, mtimecmp, mtime_inc, mtime_nxt, cmp_nxt;
  logic [31:0] prescale, snap, rd_data;
  logic        en, tick, sel, wr;
  logic [2:0]  off;
  logic [1:0]  a;

  // Right-aligned write data is steered into the addressed lanes of old.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] op, input logic [1:0] la,
                                        input logic valid);
    logic [31:0] r;
    r = old;
    if (valid) begin
      case (op)
        MEM_OP_B: r[{la, 3'b000} +: 8]     = wd[7:0];
        MEM_OP_H: r[{la[1], 4'b0000} +: 16] = wd[15:0];
        MEM_OP_W: r = wd;
        default:  r = old;
      endcase
    end
    return r;
  endfunction

  assign sel = (bus.adr[31:5] == BASE_ADDR[31:5]);
  assign off = bus.adr[4:2];
  assign a   = bus.adr[1:0];
  assign wr  = sel && bus.we && lane_ok(bus.op, a);

  mtimer_prescaler u_psc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .prescale (prescale),
    .clr      (wr && off == OFF_PRESCALE),
    .tick     (tick)
  );

  // Merging onto the incremented value lets a write win only on the lanes it touches.
  assign mtime_inc = tick ? mtime + CNT_WIDTH'(1) : mtime;
  assign mtime_nxt = {merge(mtime_inc[63:32], bus.wdin, bus.op, a, wr && off == OFF_MTIME_HI),
                      merge(mtime_inc[31:0],  bus.wdin, bus.op, a, wr && off == OFF_MTIME_LO)};
  assign cmp_nxt   = {merge(mtimecmp[63:32], bus.wdin, bus.op, a, wr && off == OFF_CMP_HI),
                      merge(mtimecmp[31:0],  bus.wdin, bus.op, a, wr && off == OFF_CMP_LO)};

  always_comb begin
    rd_data = 32'h0;
    case (off)
      OFF_MTIME_LO: rd_data = mtime[31:0];
      OFF_MTIME_HI: rd_data = mtime[63:32];
      OFF_CMP_LO:   rd_data = mtimecmp[31:0];
      OFF_CMP_HI:   rd_data = mtimecmp[63:32];
      OFF_CTRL:     rd_data = 32'(en);
      OFF_PRESCALE: rd_data = prescale;
      OFF_SNAP_HI:  rd_data = snap;
      default:      rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      en        <= 1'b0;
      prescale  <= '0;
      snap      <= '0;
      bus.rdo   <= '0;
      bus.hit   <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      mtime    <= mtime_nxt;
      mtimecmp <= cmp_nxt;
      prescale <= merge(prescale, bus.wdin, bus.op, a, wr && off == OFF_PRESCALE);
      // Only EN is stored; any accepted write covering lane 0 starts at adr[1:0]==0.
      if (wr && off == OFF_CTRL && a == 2'b00) en <= bus.wdin[CTRL_EN_BIT];
      // Latch the high half alongside a low read so 64-bit reads are coherent.
      if (sel && !bus.we && off == OFF_MTIME_LO) snap <= mtime[63:32];
      bus.rdo   <= sel ? rd_data : 32'h0;
      bus.hit   <= sel;
      timer_irq <= en && (mtime >= mtimecmp);
    end
  end
endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: register table plus timing sequences.
module tb_mtimer;
  import mtimer_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic timer_irq;
  int   total = 0;
  int   bad = 0;

  mtimer_if bus ();

  mtimer #(.BASE_ADDR(BASE), .CNT_WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  off;
    logic [1:0]  op;
    logic        we;
    logic [31:0] wdin;
    logic [31:0] exp_rdo;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [7:0] o, logic [1:0] op, logic we,
                              logic [31:0] d, logic [31:0] er, logic eh);
    vec_t v;
    v.name = n; v.off = o; v.op = op; v.we = we; v.wdin = d; v.exp_rdo = er; v.exp_hit = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Both tasks start and end at a negedge; the access happens on the posedge between.
  task automatic wr(input logic [7:0] o, input logic [31:0] d);
    bus.adr = BASE + {24'h0, o}; bus.op = MEM_OP_W; bus.we = 1'b1; bus.wdin = d;
    @(negedge clk);
    bus.we = 1'b0; bus.adr = 32'h0;
  endtask

  task automatic rd(input logic [7:0] o, output logic [31:0] d);
    bus.adr = BASE + {24'h0, o}; bus.op = MEM_OP_W; bus.we = 1'b0;
    @(negedge clk);
    d = bus.rdo;
    bus.adr = 32'h0;
  endtask

  logic [31:0] v;
  logic [31:0] prev;

  initial begin
    bus.adr = BASE; bus.op = MEM_OP_W; bus.we = 1'b0; bus.wdin = 32'h0;

    // Reset held with an in-window address present
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rdo", bus.rdo, 32'h0);
      chk("rst_hit", 32'(bus.hit), 32'h0);
      chk("rst_irq", 32'(timer_irq), 32'h0);
    end
    rst_n = 1'b1;

    // Each row reads back the pre-edge value of the addressed register
    vecs.push_back(mk("cmp_lo_rst",     8'h08, MEM_OP_W, 0, 32'h0,        32'hFFFF_FFFF, 1));
    vecs.push_back(mk("cmp_hi_rst",     8'h0C, MEM_OP_W, 0, 32'h0,        32'hFFFF_FFFF, 1));
    vecs.push_back(mk("mtime_lo_rst",   8'h00, MEM_OP_W, 0, 32'h0,        32'h0,         1));
    vecs.push_back(mk("wr_b09",         8'h09, MEM_OP_B, 1, 32'h0000_00AB, 32'hFFFF_FFFF, 1));
    vecs.push_back(mk("cmp_lo_b09",     8'h08, MEM_OP_W, 0, 32'h0,        32'hFFFF_ABFF, 1));
    vecs.push_back(mk("wr_h0b",         8'h0B, MEM_OP_H, 1, 32'h0000_1234, 32'hFFFF_ABFF, 1));
    vecs.push_back(mk("half_misalign",  8'h08, MEM_OP_W, 0, 32'h0,        32'hFFFF_ABFF, 1));
    vecs.push_back(mk("wr_w0a",         8'h0A, MEM_OP_W, 1, 32'h0,        32'hFFFF_ABFF, 1));
    vecs.push_back(mk("word_misalign",  8'h08, MEM_OP_W, 0, 32'h0,        32'hFFFF_ABFF, 1));
    vecs.push_back(mk("out_of_window",  8'h20, MEM_OP_W, 1, 32'h5555_5555, 32'h0,         0));
    vecs.push_back(mk("mtime_untouch",  8'h00, MEM_OP_W, 0, 32'h0,        32'h0,         1));
    vecs.push_back(mk("rd_outside",     8'h24, MEM_OP_W, 0, 32'h0,        32'h0,         0));
    vecs.push_back(mk("wr_h0e",         8'h0E, MEM_OP_H, 1, 32'h0000_1234, 32'hFFFF_FFFF, 1));
    vecs.push_back(mk("cmp_hi_h0e",     8'h0C, MEM_OP_W, 0, 32'h0,        32'h1234_FFFF, 1));
    vecs.push_back(mk("wr_psc",         8'h14, MEM_OP_W, 1, 32'hDEAD_BEEF, 32'h0,         1));
    vecs.push_back(mk("psc_rb",         8'h14, MEM_OP_W, 0, 32'h0,        32'hDEAD_BEEF, 1));
    vecs.push_back(mk("wr_snap",        8'h18, MEM_OP_W, 1, 32'h1234_5678, 32'h0,         1));
    vecs.push_back(mk("snap_ro",        8'h18, MEM_OP_W, 0, 32'h0,        32'h0,         1));
    vecs.push_back(mk("wr_1c",          8'h1C, MEM_OP_W, 1, 32'h1,        32'h0,         1));
    vecs.push_back(mk("rd_1c",          8'h1C, MEM_OP_W, 0, 32'h0,        32'h0,         1));
    vecs.push_back(mk("wr_ctrl_fe",     8'h10, MEM_OP_W, 1, 32'hFFFF_FFFE, 32'h0,         1));
    vecs.push_back(mk("ctrl_en_only",   8'h10, MEM_OP_W, 0, 32'h0,        32'h0,         1));
    vecs.push_back(mk("wr_ctrl_b11",    8'h11, MEM_OP_B, 1, 32'h0000_00FF, 32'h0,         1));
    vecs.push_back(mk("ctrl_lane1",     8'h10, MEM_OP_W, 0, 32'h0,        32'h0,         1));
    vecs.push_back(mk("wr_ctrl_b10",    8'h10, MEM_OP_B, 1, 32'h0000_0001, 32'h0,         1));
    vecs.push_back(mk("ctrl_byte_en",   8'h10, MEM_OP_W, 0, 32'h0,        32'h1,         1));
    vecs.push_back(mk("wr_ctrl_0",      8'h10, MEM_OP_W, 1, 32'h0,        32'h1,         1));
    vecs.push_back(mk("ctrl_off",       8'h10, MEM_OP_W, 0, 32'h0,        32'h0,         1));

    @(negedge clk);
    foreach (vecs[i]) begin
      bus.adr = BASE + {24'h0, vecs[i].off}; bus.op = vecs[i].op;
      bus.we = vecs[i].we; bus.wdin = vecs[i].wdin;
      @(negedge clk);
      bus.we = 1'b0; bus.adr = 32'h0;
      chk({vecs[i].name, "_rdo"}, bus.rdo, vecs[i].exp_rdo);
      chk({vecs[i].name, "_hit"}, 32'(bus.hit), 32'(vecs[i].exp_hit));
      chk({vecs[i].name, "_irq"}, 32'(timer_irq), 32'h0);
    end

    // PRESCALE=3: mtime after edge k of counting is k/4
    wr(8'h14, 32'd3); wr(8'h00, 32'h0); wr(8'h04, 32'h0); wr(8'h10, 32'h1);
    for (int i = 0; i < 16; i++) begin
      rd(8'h00, v);
      chk("psc3_count", v, 32'(i / 4));
    end

    // PRESCALE=0: consecutive reads step by one
    wr(8'h14, 32'd0);
    rd(8'h00, prev);
    for (int i = 0; i < 5; i++) begin
      rd(8'h00, v);
      chk("psc0_step", v, prev + 32'd1);
      prev = v;
    end

    // Wrap through all-ones to zero
    wr(8'h10, 32'h0); wr(8'h14, 32'h0);
    wr(8'h04, 32'hFFFF_FFFF); wr(8'h00, 32'hFFFF_FFFE); wr(8'h10, 32'h1);
    rd(8'h04, v); chk("wrap_hi_fe", v, 32'hFFFF_FFFF);
    rd(8'h00, v); chk("wrap_lo_ff", v, 32'hFFFF_FFFF);
    rd(8'h04, v); chk("wrap_hi_0",  v, 32'h0);
    rd(8'h00, v); chk("wrap_lo_1",  v, 32'h1);

    // Snapshot follows lo reads, not the live high half
    wr(8'h10, 32'h0); wr(8'h04, 32'h1); wr(8'h00, 32'h5);
    rd(8'h18, v); chk("snap_before", v, 32'h0);
    rd(8'h00, v); chk("snap_lo",     v, 32'h5);
    rd(8'h18, v); chk("snap_hi",     v, 32'h1);

    // Interrupt at mtime >= 10, dropped by raising CMP_LO
    wr(8'h14, 32'h0); wr(8'h0C, 32'h0); wr(8'h08, 32'd10);
    wr(8'h00, 32'h0); wr(8'h04, 32'h0); wr(8'h10, 32'h1);
    for (int i = 1; i <= 14; i++) begin
      rd(8'h00, v);
      chk("irq_cnt", v, 32'(i - 1));
      chk("irq_lvl", 32'(timer_irq), (i - 1 >= 10) ? 32'h1 : 32'h0);
    end
    wr(8'h08, 32'd100);
    chk("irq_cmp_edge", 32'(timer_irq), 32'h1);
    @(negedge clk);
    chk("irq_fall", 32'(timer_irq), 32'h0);

    // Write on a tick edge keeps wdin
    wr(8'h00, 32'h0000_1000);
    rd(8'h00, v); chk("collision_lo", v, 32'h0000_1000);

    // Async reset while counting with irq, hit and rdo all active
    wr(8'h0C, 32'h0); wr(8'h08, 32'h0);
    rd(8'h00, v);
    chk("pre_rst_irq", 32'(timer_irq), 32'h1);
    chk("pre_rst_hit", 32'(bus.hit), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rdo", bus.rdo, 32'h0);
    chk("midrst_hit", 32'(bus.hit), 32'h0);
    chk("midrst_irq", 32'(timer_irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(8'h08, v); chk("post_rst_cmp", v, 32'hFFFF_FFFF);
    rd(8'h10, v); chk("post_rst_ctrl", v, 32'h0);
    rd(8'h00, v); chk("post_rst_lo0", v, 32'h0);
    rd(8'h00, v); chk("post_rst_lo1", v, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
